motor_drive_ctrl: RTL and testbench

Multi-channel PWM motor drive stage with an independent sign-magnitude output per channel. Each channel accepts a signed two's-complement drive command and produces pwm and dir pins. Per channel it adds slew-rate limiting of the duty and a timed dead interval on every direction reversal. It sits between the PID controllers (one per wheel) and the H-bridge pins, and replaces the single-channel pwm/dir path of the motor controller.

---
 rtl/motor_drive_pkg.sv | 28 ++
 rtl/motor_drive_ch.sv | 131 +++++++++++++
 rtl/motor_drive_ctrl.sv | 62 ++++++
 tb/tb_motor_drive_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_drive_pkg.sv
// Shared types and helpers for the multi-channel PWM motor drive stage.
package motor_drive_pkg;

  // Per-channel operating state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } ch_state_t;

  // Widest command word the magnitude helper accepts; narrower commands are
  // sign-extended to this width before the call.
  localparam int ABS_W = 64;

  // Absolute value of a signed command, saturated to limit. The result carries
  // one extra bit so the most-negative input negates exactly.
  function automatic logic [ABS_W:0] abs_sat(
    input logic signed [ABS_W-1:0] cmd,
    input logic        [ABS_W:0]   limit
  );
    logic [ABS_W:0] wide;
    logic [ABS_W:0] mag;
    wide = {cmd[ABS_W-1], cmd};
    mag  = cmd[ABS_W-1] ? ((~wide) + (ABS_W+1)'(1)) : wide;
    return (mag > limit) ? limit : mag;
  endfunction

endpackage

// File: rtl/motor_drive_ch.sv
// One motor channel: command decode, slew limiting, direction-reversal dead
// interval and the registered pwm pin. The period counter is shared and
// supplied by the parent.
module motor_drive_ch
  import motor_drive_pkg::*;
#(
  parameter int BAND_WIDTH       = 32,
  parameter int PERIOD_CYCLES    = 4000,
  parameter int SLEW_STEP        = 16,
  parameter int DEAD_TIME_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [BAND_WIDTH-1:0] cmd,
  input  logic [BAND_WIDTH-1:0] cnt,
  input  logic                  tick,
  output logic                  pwm,
  output logic                  dir,
  output logic [BAND_WIDTH-1:0] duty,
  output logic                  reversing
);

  // A zero dead time still spends one cycle in DEAD so dir never flips in
  // the same cycle as the last pwm pulse could be emitted.
  localparam int DEAD_LOAD = (DEAD_TIME_CYCLES > 1) ? DEAD_TIME_CYCLES : 1;
  localparam int DCW       = $clog2(DEAD_LOAD + 1);

  localparam logic [DCW-1:0]        DEAD_LOAD_W = DCW'(DEAD_LOAD);
  localparam logic [BAND_WIDTH-1:0] STEP_W      = BAND_WIDTH'(SLEW_STEP);
  localparam logic [ABS_W:0]        MAG_LIMIT   = (ABS_W+1)'(PERIOD_CYCLES);

  ch_state_t              state;
  logic                   pend_dir;
  logic [DCW-1:0]         dead_cnt;

  logic signed [ABS_W-1:0] cmd_ext;
  logic [ABS_W:0]          mag_wide;
  logic [BAND_WIDTH-1:0]   tgt_mag;
  logic                    tgt_sign;
  logic                    req;
  logic                    rev_pend;
  logic [BAND_WIDTH-1:0]   eff_tgt;
  logic [BAND_WIDTH-1:0]   slew_next;

  // Decode the request: saturated magnitude, sign, and whether it asks for
  // the opposite direction from the one currently driven.
  assign cmd_ext  = ABS_W'($signed(cmd));
  assign mag_wide = abs_sat(cmd_ext, MAG_LIMIT);
  assign tgt_mag  = BAND_WIDTH'(mag_wide);
  assign tgt_sign = cmd[BAND_WIDTH-1];
  assign req      = |cmd;
  assign rev_pend = req && (tgt_sign != dir);

  assign reversing = (state == DEAD);

  // Next duty for a tick in RUN: head toward the target (zero while a
  // reversal is pending), moving at most SLEW_STEP per period.
  always_comb begin
    eff_tgt   = rev_pend ? '0 : tgt_mag;
    slew_next = eff_tgt;
    if (SLEW_STEP != 0) begin
      if (duty < eff_tgt) begin
        if ((eff_tgt - duty) > STEP_W) begin
          slew_next = duty + STEP_W;
        end
      end else if (duty > eff_tgt) begin
        if ((duty - eff_tgt) > STEP_W) begin
          slew_next = duty - STEP_W;
        end
      end
    end
  end

  // Channel FSM with registered pwm, dir, duty and dead counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      duty     <= '0;
      dir      <= 1'b0;
      pend_dir <= 1'b0;
      dead_cnt <= '0;
      pwm      <= 1'b0;
    end else if (!en) begin
      // Disable is immediate and keeps the last direction.
      state    <= IDLE;
      duty     <= '0;
      dead_cnt <= '0;
      pwm      <= 1'b0;
    end else begin
      pwm <= (state == RUN) && (cnt < duty);
      unique case (state)
        IDLE: begin
          duty <= '0;
          if (tick) begin
            state <= RUN;
            if (req) begin
              dir <= tgt_sign;
            end
          end
        end
        RUN: begin
          if (tick) begin
            if (rev_pend && (duty == '0)) begin
              pend_dir <= tgt_sign;
              dead_cnt <= DEAD_LOAD_W;
              state    <= DEAD;
            end else begin
              duty <= slew_next;
            end
          end
        end
        DEAD: begin
          duty <= '0;
          if (dead_cnt <= DCW'(1)) begin
            dir      <= pend_dir;
            dead_cnt <= '0;
            state    <= RUN;
          end else begin
            dead_cnt <= dead_cnt - DCW'(1);
          end
        end
        default: begin
          state <= IDLE;
          duty  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/motor_drive_ctrl.sv
// Multi-channel sign-magnitude PWM drive: one shared period counter feeding
// NUM_CH independent channel engines.
module motor_drive_ctrl
  import motor_drive_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int BAND_WIDTH       = 32,
  parameter int CLK_FREQ         = 100_000_000,
  parameter int PWM_PERIOD_US    = 40,
  parameter int SLEW_STEP        = 16,
  parameter int DEAD_TIME_CYCLES = 1000
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NUM_CH-1:0]                   en,
  input  logic [NUM_CH-1:0][BAND_WIDTH-1:0]   cmd,
  output logic [NUM_CH-1:0]                   pwm,
  output logic [NUM_CH-1:0]                   dir,
  output logic [NUM_CH-1:0][BAND_WIDTH-1:0]   duty,
  output logic [NUM_CH-1:0]                   reversing,
  output logic                                period_tick
);

  localparam int PWM_PERIOD_CYCLE = (CLK_FREQ / 1_000_000) * PWM_PERIOD_US;
  localparam logic [BAND_WIDTH-1:0] CNT_LAST = BAND_WIDTH'(PWM_PERIOD_CYCLE - 1);

  logic [BAND_WIDTH-1:0] cnt;

  assign period_tick = (cnt == CNT_LAST);

  // Shared period counter, 0..PWM_PERIOD_CYCLE-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + BAND_WIDTH'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    motor_drive_ch #(
      .BAND_WIDTH       (BAND_WIDTH),
      .PERIOD_CYCLES    (PWM_PERIOD_CYCLE),
      .SLEW_STEP        (SLEW_STEP),
      .DEAD_TIME_CYCLES (DEAD_TIME_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en[gi]),
      .cmd       (cmd[gi]),
      .cnt       (cnt),
      .tick      (period_tick),
      .pwm       (pwm[gi]),
      .dir       (dir[gi]),
      .duty      (duty[gi]),
      .reversing (reversing[gi])
    );
  end

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Bench for motor_drive_ctrl: directed scenarios plus randomized commands,
// checked cycle by cycle against a behavioural model. Two DUTs share stimulus:
// dut_a uses SLEW_STEP=10, dut_b uses SLEW_STEP=0.
module tb_motor_drive_ctrl;

  localparam int P      = 100;
  localparam int SLEW_A = 10;
  localparam int DEAD_N = 20;

  logic             clk = 1'b0;
  logic             rstn;
  logic [1:0]       en;
  logic [1:0][31:0] cmd;

  logic [1:0]       pwm_a, dir_a, rev_a, pwm_b, dir_b, rev_b;
  logic [1:0][31:0] duty_a, duty_b;
  logic             tick_a, tick_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  motor_drive_ctrl #(
    .NUM_CH(2), .BAND_WIDTH(32), .CLK_FREQ(1_000_000), .PWM_PERIOD_US(100),
    .SLEW_STEP(SLEW_A), .DEAD_TIME_CYCLES(DEAD_N)
  ) dut_a (
    .clk(clk), .rstn(rstn), .en(en), .cmd(cmd), .pwm(pwm_a), .dir(dir_a),
    .duty(duty_a), .reversing(rev_a), .period_tick(tick_a)
  );

  motor_drive_ctrl #(
    .NUM_CH(2), .BAND_WIDTH(32), .CLK_FREQ(1_000_000), .PWM_PERIOD_US(100),
    .SLEW_STEP(0), .DEAD_TIME_CYCLES(DEAD_N)
  ) dut_b (
    .clk(clk), .rstn(rstn), .en(en), .cmd(cmd), .pwm(pwm_b), .dir(dir_b),
    .duty(duty_b), .reversing(rev_b), .period_tick(tick_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index k: 0,1 = dut_a channels; 2,3 = dut_b channels.
  int m_cnt;
  bit m_tick;
  bit m_on  [4];
  int m_dl  [4];   // remaining dead cycles, 0 = not in dead interval
  int m_d   [4];
  bit m_dr  [4];
  bit m_pd  [4];
  bit m_pwm [4];

  task automatic model_step(input int k, input bit tk);
    int     ch, slew;
    longint c, mag, tgt, delta;
    bit     sgn, rev;
    ch   = k % 2;
    slew = (k < 2) ? SLEW_A : 0;
    if (!en[ch]) begin
      m_on[k] = 0; m_dl[k] = 0; m_d[k] = 0; m_pwm[k] = 0;
      return;
    end
    m_pwm[k] = m_on[k] && (m_dl[k] == 0) && (m_cnt < m_d[k]);
    c   = longint'($signed(cmd[ch]));
    sgn = (c < 0);
    mag = sgn ? -c : c;
    if (mag > P) mag = P;
    if (m_dl[k] > 0) begin
      m_dl[k]--;
      if (m_dl[k] == 0) m_dr[k] = m_pd[k];
    end else if (!m_on[k]) begin
      if (tk) begin
        m_on[k] = 1;
        if (c != 0) m_dr[k] = sgn;
      end
    end else if (tk) begin
      rev = (c != 0) && (sgn != m_dr[k]);
      if (rev && m_d[k] == 0) begin
        m_pd[k] = sgn;
        m_dl[k] = DEAD_N;
      end else begin
        tgt   = rev ? 0 : mag;
        delta = tgt - m_d[k];
        if (slew > 0) begin
          if (delta > slew)  delta = slew;
          if (delta < -slew) delta = -slew;
        end
        m_d[k] = m_d[k] + int'(delta);
      end
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt  = 0;
      m_tick = 0;
      for (int k = 0; k < 4; k++) begin
        m_on[k] = 0; m_dl[k] = 0; m_d[k] = 0; m_dr[k] = 0; m_pd[k] = 0; m_pwm[k] = 0;
      end
    end else begin
      bit tk;
      tk = (m_cnt == P - 1);
      for (int k = 0; k < 4; k++) model_step(k, tk);
      m_cnt  = tk ? 0 : m_cnt + 1;
      m_tick = (m_cnt == P - 1);
    end
  end

  // Cycle-by-cycle comparison, 3 time units after each rising edge.
  always begin
    @(posedge clk);
    #3;
    for (int ch = 0; ch < 2; ch++) begin
      check($sformatf("a%0d", ch),
            {29'd0, pwm_a[ch], dir_a[ch], rev_a[ch], duty_a[ch]},
            {29'd0, m_pwm[ch], m_dr[ch], (m_dl[ch] > 0), 32'(m_d[ch])});
      check($sformatf("b%0d", ch),
            {29'd0, pwm_b[ch], dir_b[ch], rev_b[ch], duty_b[ch]},
            {29'd0, m_pwm[ch+2], m_dr[ch+2], (m_dl[ch+2] > 0), 32'(m_d[ch+2])});
    end
    check("tick", 64'({tick_a, tick_b}), 64'({m_tick, m_tick}));
  end

  // ---------------- directed helpers ----------------
  task automatic next_period();
    int w;
    w = 0;
    while (!tick_a && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("tick_seen", 64'(tick_a), 64'd1);
    @(negedge clk);
  endtask

  task automatic count_pwm0(output int n);
    n = 0;
    for (int i = 0; i < P; i++) begin
      if (pwm_a[0]) n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    int exp_ramp[4] = '{10, 20, 30, 35};

    rstn = 1'b0; en = 2'b00; cmd = '0;
    repeat (3) @(negedge clk);

    // 1. reset values and period tick cadence
    check("rst_pwm",  64'({pwm_a, pwm_b}), 64'd0);
    check("rst_dir",  64'({dir_a, dir_b}), 64'd0);
    check("rst_duty", 64'(duty_a) | 64'(duty_b), 64'd0);
    check("rst_rev",  64'({rev_a, rev_b}), 64'd0);
    rstn = 1'b1;
    k = 0;
    while (!tick_a && k < 300) begin @(negedge clk); k++; end
    check("first_tick", 64'(k), 64'd99);
    @(negedge clk);
    k = 1;
    while (!tick_a && k < 300) begin @(negedge clk); k++; end
    check("tick_gap", 64'(k), 64'd100);

    // 2. ramp up to 35
    en[0] = 1'b1; cmd[0] = 32'd35;
    next_period();
    check("run_duty0", 64'(duty_a[0]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      next_period();
      check($sformatf("ramp%0d", i), 64'(duty_a[0]), 64'(exp_ramp[i]));
    end
    count_pwm0(n);
    check("hi35", 64'(n), 64'd35);
    check("ch1_idle", 64'(duty_a[1]), 64'd0);

    // 3. reversal from +30 to -20
    cmd[0] = 32'd30;
    next_period();
    check("steady30", 64'(duty_a[0]), 64'd30);
    cmd[0] = -32'sd20;
    for (int i = 0; i < 3; i++) begin
      next_period();
      check($sformatf("down%0d", i), 64'(duty_a[0]), 64'(20 - 10 * i));
    end
    next_period();
    check("dead_rev", 64'(rev_a[0]), 64'd1);
    k = 0;
    while (rev_a[0] && k < 100) begin k++; @(negedge clk); end
    check("dead_len", 64'(k), 64'd20);
    check("dir_neg", 64'(dir_a[0]), 64'd1);
    next_period();
    check("up10", 64'(duty_a[0]), 64'd10);
    next_period();
    check("up20", 64'(duty_a[0]), 64'd20);

    // 4. saturation and most-negative command
    cmd[0] = 32'd1000;
    repeat (15) next_period();
    check("sat_duty", 64'(duty_a[0]), 64'd100);
    check("sat_dir", 64'(dir_a[0]), 64'd0);
    count_pwm0(n);
    check("hi100", 64'(n), 64'd100);
    cmd[0] = 32'h8000_0000;
    repeat (24) next_period();
    check("minneg_duty", 64'(duty_a[0]), 64'd100);
    check("minneg_dir", 64'(dir_a[0]), 64'd1);

    // 5. disable mid-period
    cmd[0] = -32'sd50;
    repeat (7) next_period();
    check("steady50", 64'(duty_a[0]), 64'd50);
    repeat (30) @(negedge clk);
    check("mid_pwm", 64'(pwm_a[0]), 64'd1);
    en[0] = 1'b0;
    @(negedge clk);
    check("dis_pwm", 64'(pwm_a[0]), 64'd0);
    check("dis_duty", 64'(duty_a[0]), 64'd0);
    check("dis_dir", 64'(dir_a[0]), 64'd1);
    en[0] = 1'b1;
    next_period();
    check("reen0", 64'(duty_a[0]), 64'd0);
    next_period();
    check("reen10", 64'(duty_a[0]), 64'd10);

    // 6. reset during DEAD, then restart; no-slew build jumps straight
    cmd[0] = 32'd40;
    next_period();
    next_period();
    check("pre_rst_dead", 64'(rev_a[0]), 64'd1);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("arst_pwm",  64'({pwm_a, pwm_b}), 64'd0);
    check("arst_dir",  64'({dir_a, dir_b}), 64'd0);
    check("arst_duty", 64'(duty_a) | 64'(duty_b), 64'd0);
    check("arst_rev",  64'({rev_a, rev_b}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    cmd[0] = 32'd60;
    next_period();
    check("restart_dir", 64'(dir_a[0]), 64'd0);
    next_period();
    check("noslew60", 64'(duty_b[0]), 64'd60);
    check("slew10", 64'(duty_a[0]), 64'd10);

    // randomized phase, checked by the per-cycle model comparison
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(1, 400)) @(negedge clk);
      if ($urandom_range(0, 29) == 0) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end
      for (int c = 0; c < 2; c++) begin
        en[c] = ($urandom_range(0, 7) != 0);
        case ($urandom_range(0, 5))
          0:       cmd[c] = 32'd0;
          1:       cmd[c] = 32'h8000_0000;
          2:       cmd[c] = 32'h7fff_ffff;
          3:       cmd[c] = $urandom;
          default: cmd[c] = 32'(int'($urandom_range(0, 240)) - 120);
        endcase
      end
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
